// File: rtl/arb_pkg.sv
// Shared types for the interface-array round-robin arbiter.
package arb_pkg;

  // IDLE: waiting for any requester. GRANT: one owner is locked until its last beat.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_intf.sv
// Per-lane requester link: a producer drives req/data/last and receives gnt.
interface arb_intf #(
  parameter int W = 8
);
  logic         req;
  logic [W-1:0] data;
  logic         last;
  logic         gnt;

  modport requester (output req, output data, output last, input gnt);
  modport arbiter   (input req, input data, input last, output gnt);
endinterface

// File: rtl/intf_array_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set bit scanning ptr, ptr+1, ... mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_vec,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          any
);

  // Walk from the lowest priority to the highest so the nearest hit to ptr is written last.
  always_comb begin
    idx = '0;
    any = |req_vec;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_vec[(int'(ptr) + k) % N]) begin
        idx = SW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/intf_array_arbiter.sv
// Round-robin, packet-locked arbiter merging an array of requester lanes into one
// registered output stream.
//
// Handshake semantics (both sides): a beat moves only in a cycle where the
// producer's qualifier (req / out_valid) and the consumer's acceptance
// (gnt / out_ready) are high together. req, data and last stay stable until
// granted; out_valid, out_data, out_last and out_src stay stable until out_ready.
module intf_array_arbiter
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  arb_intf.arbiter      reqs [N-1:0],
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [SW-1:0] out_src,
  input  logic          out_ready,
  output logic          busy
);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [SW-1:0] r_owner;
  logic [SW-1:0] w_owner_nxt;
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] w_ptr_nxt;
  logic [SW-1:0] w_owner_inc;

  logic [N-1:0]  w_req_vec;
  logic [N-1:0]  w_last_vec;
  logic [W-1:0]  w_data_arr [N];
  logic [N-1:0]  w_gnt_vec;

  logic [SW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic          w_can_accept;
  logic          w_xfer;
  logic          w_xfer_last;

  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_out_last;
  logic [SW-1:0] r_out_src;

  // Flatten the interface array into plain vectors and fan the grant back out.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign w_req_vec[i]  = reqs[i].req;
    assign w_last_vec[i] = reqs[i].last;
    assign w_data_arr[i] = reqs[i].data;
    assign reqs[i].gnt   = w_gnt_vec[i];
  end

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req_vec (w_req_vec),
    .ptr     (r_ptr),
    .idx     (w_pick_idx),
    .any     (w_pick_any)
  );

  assign w_can_accept = !r_out_valid || out_ready;
  assign w_xfer       = |(w_gnt_vec & w_req_vec);
  assign w_xfer_last  = w_last_vec[r_owner];
  assign w_owner_inc  = (r_owner == SW'(N - 1)) ? '0 : r_owner + SW'(1);

  // Owner decode: only the locked owner sees gnt, and only when the output stage has room.
  always_comb begin
    w_gnt_vec = '0;
    if ((r_state == GRANT) && w_can_accept) begin
      w_gnt_vec[r_owner] = 1'b1;
    end
  end

  // Grant FSM next state: pick on IDLE, release and rotate priority after the last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_owner_nxt = w_pick_idx;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_xfer && w_xfer_last) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_owner_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant FSM state, owner and rotating pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // One-entry output stage: load on a transfer, otherwise clear once drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data_arr[r_owner];
      r_out_last  <= w_xfer_last;
      r_out_src   <= r_owner;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_src   = r_out_src;
  assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_intf_array_arbiter.sv
// Bench for intf_array_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_intf_array_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int SW  = 2;
  localparam int SBW = SW + 1 + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          tb_rst_n;
  logic          tb_ready;
  logic [N-1:0]  tb_req;
  logic [N-1:0]  tb_last;
  logic [W-1:0]  tb_data [N];
  logic [N-1:0]  gnt_v;

  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [SW-1:0] out_src;
  logic          busy;

  arb_intf #(.W(W)) lanes [N-1:0] ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign lanes[g].req  = tb_req[g];
    assign lanes[g].data = tb_data[g];
    assign lanes[g].last = tb_last[g];
    assign gnt_v[g]      = lanes[g].gnt;
  end

  intf_array_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (tb_rst_n),
    .reqs      (lanes),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (tb_ready),
    .busy      (busy)
  );

  // ---------------- lane producers ----------------
  int         rem    [N];
  logic [7:0] beat   [N];
  logic [7:0] base   [N];
  logic       hold   [N];
  logic       refill [N];

  // ---------------- reference model ----------------
  logic          m_grant;
  int            m_owner;
  int            m_ptr;
  logic          m_ov;
  logic [W-1:0]  m_od;
  logic          m_ol;
  logic [SW-1:0] m_os;
  logic [SBW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_lanes();
    for (int i = 0; i < N; i++) begin
      tb_req[i]  = (rem[i] > 0) && !hold[i];
      tb_data[i] = base[i] + beat[i];
      tb_last[i] = (rem[i] == 1);
    end
  endtask

  task automatic start_pkt(input int lane, input int len, input logic [7:0] b);
    rem[lane]  = len;
    beat[lane] = 8'd0;
    base[lane] = b;
    apply_lanes();
  endtask

  task automatic model_reset();
    m_grant = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_ov    = 1'b0;
    m_od    = '0;
    m_ol    = 1'b0;
    m_os    = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      hold[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs that were present before it.
  task automatic model_update();
    logic ca;
    logic xf;
    int   o;
    if (!tb_rst_n) begin
      model_reset();
      return;
    end
    o  = m_owner;
    ca = !m_ov || tb_ready;
    xf = m_grant && ca && tb_req[o];
    if (xf) begin
      m_ov = 1'b1;
      m_od = tb_data[o];
      m_ol = tb_last[o];
      m_os = o[SW-1:0];
      exp_q.push_back({o[SW-1:0], tb_last[o], tb_data[o]});
    end else if (m_ov && tb_ready) begin
      m_ov = 1'b0;
    end
    if (!m_grant) begin
      for (int k = 0; k < N; k++) begin
        if (tb_req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_grant = 1'b1;
          break;
        end
      end
    end else if (xf && tb_last[o]) begin
      m_grant = 1'b0;
      m_ptr   = (o + 1) % N;
    end
    if (xf) begin
      beat[o] = beat[o] + 8'd1;
      rem[o]  = rem[o] - 1;
      if (rem[o] == 0 && refill[o]) begin
        rem[o]  = 1;
        beat[o] = 8'd0;
        base[o] = 8'($urandom);
      end
    end
  endtask

  // One clock: compare everything against the model, then step both across the edge.
  task automatic cycle();
    logic [N-1:0]   eg;
    logic [SBW-1:0] item;
    apply_lanes();
    #1;
    eg = '0;
    if (m_grant && (!m_ov || tb_ready)) eg[m_owner] = 1'b1;
    chk("gnt", gnt_v, eg);
    chk("busy", busy, m_grant);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_last", out_last, m_ol);
    chk("out_src", out_src, m_os);
    if (m_ov && tb_ready) begin
      chk("sb_nonempty", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        chk("sb_src", out_src, item[SBW-1 -: SW]);
        chk("sb_last", out_last, item[W]);
        chk("sb_data", out_data, item[W-1:0]);
      end
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    apply_lanes();
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) refill[i] = 1'b0;
    tb_rst_n = 1'b0;
    cycle();
    cycle();
    tb_rst_n = 1'b1;
  endtask

  task automatic drain();
    logic pending;
    for (int i = 0; i < N; i++) refill[i] = 1'b0;
    tb_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      pending = m_grant || m_ov;
      for (int i = 0; i < N; i++) if (rem[i] > 0) pending = 1'b1;
      if (!pending) break;
      cycle();
    end
    pending = m_grant || m_ov;
    for (int i = 0; i < N; i++) if (rem[i] > 0) pending = 1'b1;
    chk("drain_done", pending, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] src_seq[$];
    logic          prev_v;

    tb_rst_n = 1'b0;
    tb_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      refill[i] = 1'b0;
      base[i]   = 8'd0;
      beat[i]   = 8'd0;
    end
    model_reset();
    apply_lanes();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_src", out_src, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt_v, 4'b0000);
    cycle();
    tb_rst_n = 1'b1;
    cycle();

    // 1. Single packet on lane 1
    start_pkt(1, 2, 8'hA1);
    cycle();
    chk("t1_gnt_first", gnt_v, 4'b0010);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ov_empty", out_valid, 1'b0);
    cycle();
    chk("t1_gnt_second", gnt_v, 4'b0010);
    chk("t1_ov_a1", out_valid, 1'b1);
    chk("t1_data_a1", out_data, 8'hA1);
    chk("t1_src_a1", out_src, 2'd1);
    cycle();
    chk("t1_gnt_done", gnt_v, 4'b0000);
    chk("t1_busy_fall", busy, 1'b0);
    chk("t1_data_a2", out_data, 8'hA2);
    chk("t1_last_a2", out_last, 1'b1);
    chk("t1_src_a2", out_src, 2'd1);
    cycle();
    chk("t1_ov_drained", out_valid, 1'b0);
    drain();

    // 2. Fairness from ptr=0 with all lanes continuously requesting
    do_reset();
    for (int i = 0; i < N; i++) begin
      refill[i] = 1'b1;
      start_pkt(i, 1, 8'(8'h20 + i));
    end
    prev_v = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk("t2_bubble", prev_v & out_valid, 1'b0);
      if (out_valid) src_seq.push_back(out_src);
      prev_v = out_valid;
      cycle();
    end
    chk("t2_beats", src_seq.size(), 7);
    for (int j = 0; j < 7 && j < src_seq.size(); j++) begin
      chk("t2_order", src_seq[j], j % N);
    end
    drain();

    // 3. Backpressure on lane 2 (leaves ptr=3)
    start_pkt(2, 2, 8'h55);
    cycle();
    cycle();
    chk("t3_ov", out_valid, 1'b1);
    chk("t3_data", out_data, 8'h55);
    tb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_hold_data", out_data, 8'h55);
      chk("t3_hold_gnt", gnt_v, 4'b0000);
      chk("t3_hold_ov", out_valid, 1'b1);
      cycle();
    end
    tb_ready = 1'b1;
    #1;
    chk("t3_resume_gnt", gnt_v, 4'b0100);
    cycle();
    chk("t3_reload_ov", out_valid, 1'b1);
    chk("t3_reload_data", out_data, 8'h56);
    chk("t3_reload_last", out_last, 1'b1);
    cycle();
    chk("t3_drained", out_valid, 1'b0);
    drain();

    // 4. Wrap: ptr=3, lanes 0 and 3 together
    start_pkt(0, 1, 8'h40);
    start_pkt(3, 1, 8'h43);
    cycle();
    chk("t4_first_lane3", gnt_v, 4'b1000);
    cycle();
    chk("t4_bubble", gnt_v, 4'b0000);
    cycle();
    chk("t4_second_lane0", gnt_v, 4'b0001);
    cycle();
    drain();

    // 5. Lock: lane 0 drops req mid-packet while lane 2 waits
    start_pkt(0, 3, 8'h10);
    cycle();
    chk("t5_lane0_gnt", gnt_v, 4'b0001);
    cycle();
    hold[0] = 1'b1;
    start_pkt(2, 1, 8'h20);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t5_locked", gnt_v, 4'b0001);
      chk("t5_busy", busy, 1'b1);
      cycle();
    end
    hold[0] = 1'b0;
    apply_lanes();
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t5_finish_lane0", gnt_v, 4'b0001);
      cycle();
    end
    chk("t5_idle", gnt_v, 4'b0000);
    cycle();
    chk("t5_lane2_after", gnt_v, 4'b0100);
    cycle();
    drain();

    // 6. Reset during beat 2 of a 4-beat packet (ptr=3 beforehand)
    start_pkt(1, 4, 8'h30);
    cycle();
    cycle();
    tb_rst_n = 1'b0;
    cycle();
    tb_rst_n = 1'b1;
    chk("t6_ov", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_gnt", gnt_v, 4'b0000);
    start_pkt(3, 1, 8'h63);
    start_pkt(1, 1, 8'h61);
    cycle();
    chk("t6_restart_scan", gnt_v, 4'b0010);
    cycle();
    drain();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          start_pkt(i, $urandom_range(1, 4), 8'($urandom));
        end
      end
      tb_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
    cycle();
    chk("final_sb_empty", exp_q.size(), 0);
    chk("final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intf_array_arbiter.md
# intf_array_arbiter

Round-robin, packet-locked arbiter that shares one output stream among an array of `N` requester interface instances (`arb_intf reqs [N-1:0]`). It sits between per-lane producers, each connected through its own array element, and a single downstream consumer. It owns the grant FSM, the rotating priority pointer and a one-entry registered output stage.

## Interface
Parameters:
- `N`, 4: number of requesters, ≥1.
- `W`, 8: data width per beat.
- `SW`, `$clog2(N)` (min 1): width of the source-index field.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `reqs`  interface array  `arb_intf #(W) [N-1:0]`, `arbiter` modport.
  - `req`, `data[W-1:0]` and `last` are inputs.
  - `gnt` is an output.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  beat payload.
- `out_last`  out  1  final beat of packet.
- `out_src`  out  SW  index of the requester that supplied the beat.
- `out_ready`  in  1  consumer accepts the beat when `out_valid && out_ready`.
- `busy`  out  1  high while the FSM is in GRANT.

## Operation
- `arb_intf` modports:
  - `requester`: output `req`, `data`, `last`; input `gnt`.
  - `arbiter`: the mirror of `requester`.
- Beat transfer on lane i: `reqs[i].req && reqs[i].gnt` in the same cycle.
- `can_accept = !out_valid || out_ready`.
- `gnt[i] = (state==GRANT) && (owner==i) && can_accept`. This is combinational; at most one `gnt` is high per cycle.
- FSM states: IDLE, GRANT.
  - IDLE with no `req`: stay in IDLE.
  - IDLE with any `req`: set `owner` to the first requesting index found scanning `ptr, ptr+1, …` mod N, then go to GRANT.
  - GRANT, transfer with `last=1`: go to IDLE and set `ptr <= (owner+1) mod N`.
  - GRANT, otherwise: hold `owner`. The grant stays locked even if `req` drops mid-packet; no timeout.
- Output register:
  - On a transfer, load `out_data`, `out_last`, `out_src=owner` and set `out_valid=1`.
  - Else, if `out_valid && out_ready`, clear `out_valid`.
  - Payload holds its value while `out_valid && !out_ready`.
- Requester obligations:
  - Hold `req`, `data` and `last` stable until granted.
  - Keep `req` high until its `last` beat transfers.
- `N=1`: `ptr` stays 0; the picker degenerates to lane 0.

## Timing
- Reset values:
  - `state=IDLE`, `ptr=0`, `owner=0`.
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_src=0`.
  - `busy=0`; all `gnt=0`.
- Latency:
  - `req` first seen high at edge k gives GRANT at k+1.
  - With `out_ready=1`, `gnt` is high in cycle k+1 and `out_valid` is high from k+2.
- Throughput:
  - One beat per cycle within a packet while `out_ready=1`.
  - One IDLE bubble cycle between packets, including same-requester back-to-back.
- Simultaneous events:
  - A transfer and an output drain in the same cycle reload the register; `out_valid` stays 1.
  - A `req` arriving in the same cycle a `last` transfers is considered from the next IDLE cycle, using the updated `ptr`.
- Reset mid-packet:
  - The in-flight packet is dropped.
  - The cycle after the reset edge: all `gnt=0` and `out_valid=0`.
  - Arbitration restarts from `ptr=0`.

## Structure
- Package `arb_pkg`: `typedef enum logic {IDLE, GRANT} arb_state_t`.
- `arb_intf` is defined in its own file next to the package.
- Sub-module `rr_pick #(N)`:
  - Inputs: `req_vec[N-1:0]`, `ptr`.
  - Outputs: `idx`, `any`.
  - Combinational rotate-and-priority-encode.
- Generate loop over `reqs[i]`:
  - Packs `req`, `data` and `last` into vectors.
  - Drives `reqs[i].gnt` from the owner decode.

## Test plan
All scenarios use N=4, W=8.
1. Single packet:
   - Stimulus: lane 1 sends 0xA1 then 0xA2 (`last`), `out_ready=1`.
   - Required: `gnt[1]` high for 2 cycles starting 1 cycle after `req`; `out_src=1` with data 0xA1, 0xA2 on consecutive cycles; `busy` falls after the 0xA2 beat transfers.
2. Fairness:
   - Stimulus: after reset, all four lanes request single-beat packets continuously.
   - Required: `out_src` sequence 0,1,2,3,0,1…, each beat separated by one bubble.
3. Backpressure:
   - Stimulus: `out_ready=0` for 3 cycles while `out_valid=1` with data 0x55.
   - Required: `out_data` stays 0x55; all `gnt=0`; no beat lost or duplicated after `out_ready` returns.
4. Wrap:
   - Stimulus: complete a lane 2 packet so `ptr=3`, then lanes 0 and 3 request together.
   - Required: lane 3 is served first, then lane 0.
5. Lock:
   - Stimulus: lane 0 deasserts `req` mid-packet for 2 cycles while lane 2 requests.
   - Required: lane 2 is not granted until lane 0's `last` beat transfers.
6. Reset mid-packet:
   - Stimulus: `rst_n=0` for one edge during beat 2 of a 4-beat packet.
   - Required: next cycle `out_valid=0`, `busy=0`, all `gnt=0`; after release the first grant follows the scan from `ptr=0`.
